// File: rtl/mux2_stream_arbiter.sv
// Two-source packet arbiter feeding a 2:1 data mux: grants one source per packet
// (round-robin between packets) and forwards beats through one output register.
module mux2_stream_arbiter #(
  parameter int WIDTH        = 8,
  parameter bit LOCK_ON_LAST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] A_DATA,
  input  logic             A_VALID,
  input  logic             A_LAST,
  output logic             A_READY,
  input  logic [WIDTH-1:0] B_DATA,
  input  logic             B_VALID,
  input  logic             B_LAST,
  output logic             B_READY,
  output logic [WIDTH-1:0] Y_DATA,
  output logic             Y_VALID,
  output logic             Y_LAST,
  input  logic             Y_READY,
  output logic             SEL,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;      // 0 = A next on a tie, 1 = B
  logic             sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             y_valid_q, y_valid_d;
  logic             y_last_q, y_last_d;
  logic [WIDTH-1:0] y_data_q, y_data_d;

  logic             out_free;
  logic             acc_a, acc_b;

  // The output register can take a new beat when empty or being drained.
  assign out_free = !y_valid_q || Y_READY;
  assign A_READY  = (state_q == GRANT_A) && out_free;
  assign B_READY  = (state_q == GRANT_B) && out_free;
  assign acc_a    = A_VALID && A_READY;
  assign acc_b    = B_VALID && B_READY;

  // NOTE: every next-state variable gets its hold value first, so no path
  // through this block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    sel_d     = sel_q;
    y_valid_d = y_valid_q;
    y_last_d  = y_last_q;
    y_data_d  = y_data_q;

    unique case (state_q)
      IDLE: begin
        if (A_VALID && (!B_VALID || !prio_q)) begin
          state_d = GRANT_A;
          sel_d   = 1'b0;
        end else if (B_VALID) begin
          state_d = GRANT_B;
          sel_d   = 1'b1;
        end
      end
      GRANT_A: begin
        if (acc_a && (A_LAST || !LOCK_ON_LAST)) begin
          state_d = IDLE;
          prio_d  = 1'b1;
        end
      end
      GRANT_B: begin
        if (acc_b && (B_LAST || !LOCK_ON_LAST)) begin
          state_d = IDLE;
          prio_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (acc_a) begin
      y_valid_d = 1'b1;
      y_data_d  = A_DATA;
      y_last_d  = A_LAST;
    end else if (acc_b) begin
      y_valid_d = 1'b1;
      y_data_d  = B_DATA;
      y_last_d  = B_LAST;
    end else if (Y_READY) begin
      y_valid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      sel_q     <= 1'b0;
      busy_q    <= 1'b0;
      y_valid_q <= 1'b0;
      y_last_q  <= 1'b0;
      y_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      y_valid_q <= y_valid_d;
      y_last_q  <= y_last_d;
      y_data_q  <= y_data_d;
    end
  end

  assign Y_VALID = y_valid_q;
  assign Y_DATA  = y_data_q;
  assign Y_LAST  = y_last_q;
  assign SEL     = sel_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// Bench for mux2_stream_arbiter: directed scenarios plus a randomized run checked
// against a packet-level round-robin model. A second instance has LOCK_ON_LAST=0.
module tb_mux2_stream_arbiter;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       first;
  } beat_t;

  typedef struct packed {
    logic [7:0]  data;
    logic        last;
    logic        sel;
    logic [31:0] cyc;
  } obs_t;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [7:0] A_DATA = '0, B_DATA = '0;
  logic       A_VALID = 1'b0, A_LAST = 1'b0, B_VALID = 1'b0, B_LAST = 1'b0;
  logic       Y_READY = 1'b0;

  logic       a_ready_1, b_ready_1, y_valid_1, y_last_1, sel_1, busy_1;
  logic [7:0] y_data_1;
  logic       a_ready_0, b_ready_0, y_valid_0, y_last_0, sel_0, busy_0;
  logic [7:0] y_data_0;

  always #5 CLK = ~CLK;

  mux2_stream_arbiter #(.WIDTH(8), .LOCK_ON_LAST(1'b1)) u_dut (
    .CLK(CLK), .RST_N(RST_N),
    .A_DATA(A_DATA), .A_VALID(A_VALID), .A_LAST(A_LAST), .A_READY(a_ready_1),
    .B_DATA(B_DATA), .B_VALID(B_VALID), .B_LAST(B_LAST), .B_READY(b_ready_1),
    .Y_DATA(y_data_1), .Y_VALID(y_valid_1), .Y_LAST(y_last_1), .Y_READY(Y_READY),
    .SEL(sel_1), .BUSY(busy_1)
  );

  mux2_stream_arbiter #(.WIDTH(8), .LOCK_ON_LAST(1'b0)) u_dut_nl (
    .CLK(CLK), .RST_N(RST_N),
    .A_DATA(A_DATA), .A_VALID(A_VALID), .A_LAST(A_LAST), .A_READY(a_ready_0),
    .B_DATA(B_DATA), .B_VALID(B_VALID), .B_LAST(B_LAST), .B_READY(b_ready_0),
    .Y_DATA(y_data_0), .Y_VALID(y_valid_0), .Y_LAST(y_last_0), .Y_READY(Y_READY),
    .SEL(sel_0), .BUSY(busy_0)
  );

  bit use_nl = 1'b0, gap_en = 1'b0, yr_rand = 1'b0, mon_en = 1'b0;

  logic       m_a_ready, m_b_ready, m_y_valid, m_y_last, m_sel, m_busy;
  logic [7:0] m_y_data;
  assign m_a_ready = use_nl ? a_ready_0 : a_ready_1;
  assign m_b_ready = use_nl ? b_ready_0 : b_ready_1;
  assign m_y_valid = use_nl ? y_valid_0 : y_valid_1;
  assign m_y_data  = use_nl ? y_data_0  : y_data_1;
  assign m_y_last  = use_nl ? y_last_0  : y_last_1;
  assign m_sel     = use_nl ? sel_0     : sel_1;
  assign m_busy    = use_nl ? busy_0    : busy_1;

  int    n_cmp = 0, n_fail = 0, cyc = 0;
  beat_t a_q[$], b_q[$], exp_q[$];
  obs_t  obs_q[$];
  logic  prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_beat(input bit side, input logic [7:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    if (!side) begin
      b.first = (a_q.size() == 0) || a_q[a_q.size()-1].last;
      a_q.push_back(b);
    end else begin
      b.first = (b_q.size() == 0) || b_q[b_q.size()-1].last;
      b_q.push_back(b);
    end
  endtask

  task automatic drive();
    if (a_q.size() > 0) begin
      A_DATA  = a_q[0].data;
      A_LAST  = a_q[0].last;
      A_VALID = a_q[0].first || !gap_en || ($urandom_range(2) != 0);
    end else begin
      A_DATA = '0; A_LAST = 1'b0; A_VALID = 1'b0;
    end
    if (b_q.size() > 0) begin
      B_DATA  = b_q[0].data;
      B_LAST  = b_q[0].last;
      B_VALID = b_q[0].first || !gap_en || ($urandom_range(2) != 0);
    end else begin
      B_DATA = '0; B_LAST = 1'b0; B_VALID = 1'b0;
    end
    if (yr_rand) Y_READY = ($urandom_range(3) != 0);
  endtask

  // Sample handshakes at the falling edge, advance sources after the rising edge.
  task automatic cycle();
    bit af, bf, yf;
    obs_t o;
    @(negedge CLK);
    af = A_VALID && m_a_ready;
    bf = B_VALID && m_b_ready;
    yf = m_y_valid && Y_READY;
    if (mon_en) begin
      check("one_ready", 32'(m_a_ready && m_b_ready), 32'd0);
      if (prev_stall) begin
        check("stall_valid", 32'(m_y_valid), 32'd1);
        check("stall_data", 32'(m_y_data), 32'(prev_data));
      end
    end
    prev_stall = m_y_valid && !Y_READY;
    prev_data  = m_y_data;
    if (yf) begin
      o.data = m_y_data; o.last = m_y_last; o.sel = m_sel; o.cyc = 32'(cyc);
      obs_q.push_back(o);
    end
    @(posedge CLK);
    cyc++;
    #1;
    if (af) void'(a_q.pop_front());
    if (bf) void'(b_q.pop_front());
    drive();
  endtask

  task automatic run_until(input string tag, input int n, input int budget);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin
      cycle();
      k++;
    end
    check({tag, "_timeout"}, 32'(obs_q.size() >= n), 32'd1);
  endtask

  task automatic check_out(input string tag, input int i, input logic [7:0] d,
                           input logic l, input logic s, input int c);
    if (i < obs_q.size()) begin
      check($sformatf("%s_data%0d", tag, i), 32'(obs_q[i].data), 32'(d));
      check($sformatf("%s_last%0d", tag, i), 32'(obs_q[i].last), 32'(l));
      check($sformatf("%s_sel%0d", tag, i), 32'(obs_q[i].sel), 32'(s));
      if (c >= 0) check($sformatf("%s_cyc%0d", tag, i), obs_q[i].cyc, 32'(c));
    end else begin
      check($sformatf("%s_count", tag), 32'(obs_q.size()), 32'(i + 1));
    end
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    A_VALID = 1'b0; B_VALID = 1'b0; A_LAST = 1'b0; B_LAST = 1'b0;
    A_DATA = '0; B_DATA = '0; Y_READY = 1'b0;
    a_q.delete(); b_q.delete(); obs_q.delete(); exp_q.delete();
    prev_stall = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int len;

    // Reset values
    do_reset();
    check("rst_y_valid", 32'(y_valid_1), 32'd0);
    check("rst_y_data", 32'(y_data_1), 32'd0);
    check("rst_y_last", 32'(y_last_1), 32'd0);
    check("rst_sel", 32'(sel_1), 32'd0);
    check("rst_busy", 32'(busy_1), 32'd0);
    check("rst_a_ready", 32'(a_ready_1), 32'd0);

    // Single 3-beat packet on A
    Y_READY = 1'b1;
    add_beat(0, 8'h11, 1'b0); add_beat(0, 8'h22, 1'b0); add_beat(0, 8'h33, 1'b1);
    drive();
    c0 = cyc;
    cycle();
    check("t1_busy_grant", 32'(m_busy), 32'd1);
    check("t1_sel_grant", 32'(m_sel), 32'd0);
    check("t1_yv_early", 32'(m_y_valid), 32'd0);
    run_until("t1", 3, 20);
    check_out("t1", 0, 8'h11, 1'b0, 1'b0, c0 + 2);
    check_out("t1", 1, 8'h22, 1'b0, 1'b0, c0 + 3);
    check_out("t1", 2, 8'h33, 1'b1, 1'b0, c0 + 4);
    check("t1_busy_end", 32'(m_busy), 32'd0);
    check("t1_yv_end", 32'(m_y_valid), 32'd0);

    // Both valid from reset: A first, one bubble, then B
    do_reset();
    Y_READY = 1'b1;
    add_beat(0, 8'hA0, 1'b0); add_beat(0, 8'hA1, 1'b1);
    add_beat(1, 8'hB0, 1'b0); add_beat(1, 8'hB1, 1'b1);
    drive();
    c0 = cyc;
    run_until("t2", 4, 30);
    check_out("t2", 0, 8'hA0, 1'b0, 1'b0, c0 + 2);
    check_out("t2", 1, 8'hA1, 1'b1, 1'b0, c0 + 3);
    check_out("t2", 2, 8'hB0, 1'b0, 1'b1, c0 + 5);
    check_out("t2", 3, 8'hB1, 1'b1, 1'b1, c0 + 6);

    // Output stall for 5 cycles with 0x22 pending
    do_reset();
    Y_READY = 1'b1;
    add_beat(0, 8'h11, 1'b0); add_beat(0, 8'h22, 1'b0); add_beat(0, 8'h33, 1'b1);
    drive();
    repeat (3) cycle();
    Y_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check($sformatf("t4_hold_data%0d", i), 32'(m_y_data), 32'h22);
      check($sformatf("t4_hold_valid%0d", i), 32'(m_y_valid), 32'd1);
      check($sformatf("t4_a_ready%0d", i), 32'(m_a_ready), 32'd0);
    end
    Y_READY = 1'b1;
    run_until("t4", 3, 20);
    repeat (3) cycle();
    check("t4_count", 32'(obs_q.size()), 32'd3);
    check_out("t4", 0, 8'h11, 1'b0, 1'b0, -1);
    check_out("t4", 1, 8'h22, 1'b0, 1'b0, -1);
    check_out("t4", 2, 8'h33, 1'b1, 1'b0, -1);

    // LOCK_ON_LAST=0: re-arbitrate after every beat
    use_nl = 1'b1;
    do_reset();
    Y_READY = 1'b1;
    add_beat(0, 8'hA0, 1'b0); add_beat(0, 8'hA1, 1'b0);
    add_beat(1, 8'hB0, 1'b0); add_beat(1, 8'hB1, 1'b0);
    drive();
    c0 = cyc;
    run_until("t5", 4, 30);
    check_out("t5", 0, 8'hA0, 1'b0, 1'b0, c0 + 2);
    check_out("t5", 1, 8'hB0, 1'b0, 1'b1, c0 + 4);
    check_out("t5", 2, 8'hA1, 1'b0, 1'b0, c0 + 6);
    check_out("t5", 3, 8'hB1, 1'b0, 1'b1, c0 + 8);
    use_nl = 1'b0;

    // Asynchronous reset mid B-packet, then a fresh B packet
    do_reset();
    Y_READY = 1'b1;
    add_beat(1, 8'hC0, 1'b0); add_beat(1, 8'hC1, 1'b0); add_beat(1, 8'hC2, 1'b1);
    drive();
    repeat (3) cycle();
    check("t6_pre_sel", 32'(m_sel), 32'd1);
    check("t6_pre_busy", 32'(m_busy), 32'd1);
    #2;
    RST_N = 1'b0;
    #1;
    check("t6_y_valid", 32'(m_y_valid), 32'd0);
    check("t6_y_data", 32'(m_y_data), 32'd0);
    check("t6_sel", 32'(m_sel), 32'd0);
    check("t6_busy", 32'(m_busy), 32'd0);
    check("t6_b_ready", 32'(m_b_ready), 32'd0);
    a_q.delete(); b_q.delete(); obs_q.delete();
    A_VALID = 1'b0; B_VALID = 1'b0; B_LAST = 1'b0; B_DATA = '0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    add_beat(1, 8'h5A, 1'b0); add_beat(1, 8'hA5, 1'b1);
    drive();
    c0 = cyc;
    run_until("t6", 2, 20);
    check_out("t6", 0, 8'h5A, 1'b0, 1'b1, c0 + 2);
    check_out("t6", 1, 8'hA5, 1'b1, 1'b1, c0 + 3);

    // Randomized: both sources always have a packet pending, so packets must
    // alternate A,B,A,B,... and each source's beats arrive intact and in order.
    do_reset();
    for (int p = 0; p < 5; p++) begin
      for (int s = 0; s < 2; s++) begin
        len = int'($urandom_range(4, 1));
        for (int k = 0; k < len; k++) begin
          beat_t e;
          e.data  = 8'($urandom);
          e.last  = (k == len - 1);
          e.first = (k == 0);
          add_beat(s[0], e.data, e.last);
          exp_q.push_back(e);
        end
      end
    end
    mon_en = 1'b1; gap_en = 1'b1; yr_rand = 1'b1;
    drive();
    run_until("rnd", exp_q.size(), 2000);
    mon_en = 1'b0; gap_en = 1'b0; yr_rand = 1'b0;
    check("rnd_count", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("rnd_data%0d", i), 32'(obs_q[i].data), 32'(exp_q[i].data));
      check($sformatf("rnd_last%0d", i), 32'(obs_q[i].last), 32'(exp_q[i].last));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mux2_stream_arbiter.md
Name: mux2_stream_arbiter

Overview:
- Two-input packet arbiter that sits directly upstream of the 2:1 data mux. It generates the mux select and drives the consumer with a registered output stream.
- Each of two sources (A, B) offers beats using VALID/READY/LAST. The block grants one source for a whole packet, alternating round-robin between packets, and forwards beats through a single output register.
- SEL exports the current grant so that sideband 2:1 muxes can track it.

Parameters:
- WIDTH, 8, data width of A_DATA, B_DATA and Y_DATA.
- LOCK_ON_LAST, 1, 1 = hold the grant until a beat with LAST=1 is accepted; 0 = re-arbitrate after every accepted beat.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous active-low reset.
- A_DATA  input  WIDTH  source A data.
- A_VALID  input  1  source A beat valid.
- A_LAST  input  1  source A last beat of packet.
- A_READY  output  1  source A beat accepted this cycle when A_VALID=1.
- B_DATA  input  WIDTH  source B data.
- B_VALID  input  1  source B beat valid.
- B_LAST  input  1  source B last beat of packet.
- B_READY  output  1  source B beat accepted this cycle when B_VALID=1.
- Y_DATA  output  WIDTH  registered output data.
- Y_VALID  output  1  output beat valid.
- Y_LAST  output  1  output last beat of packet.
- Y_READY  input  1  consumer accepts the output beat.
- SEL  output  1  current or most recent grant: 0 = A, 1 = B (mux select).
- BUSY  output  1  high while in GRANT_A or GRANT_B.

Behaviour:
- Reset (RST_N=0, async):
  - State IDLE.
  - Y_VALID=0, Y_DATA=0, Y_LAST=0, SEL=0, BUSY=0.
  - Priority pointer PRIO=A.
  - An in-flight output beat is discarded; sources must resend.
- States: IDLE, GRANT_A, GRANT_B. All transitions are registered.
- IDLE:
  - A_READY=B_READY=0.
  - Only A_VALID -> GRANT_A. Only B_VALID -> GRANT_B. Neither -> stay in IDLE.
  - Both valid -> grant the source pointed to by PRIO.
  - SEL updates on the same edge as the grant. SEL holds its value while in IDLE.
- GRANT_x:
  - X_READY = !Y_VALID | Y_READY. The other source's READY is 0.
  - A beat is accepted when X_VALID & X_READY. Y_DATA/Y_LAST load X_DATA/X_LAST and Y_VALID=1 on the next edge.
- Output register:
  - Y_VALID clears on an edge with Y_READY=1 and no new accepted beat.
  - Y_DATA and Y_LAST hold stable while Y_VALID=1 and Y_READY=0.
- End of grant:
  - Grant ends on an accepted beat with LAST=1 (LOCK_ON_LAST=1), or on any accepted beat (LOCK_ON_LAST=0).
  - When the grant ends: next state is IDLE and PRIO points to the other source.
- Latency and throughput:
  - From IDLE, a beat is accepted 1 cycle after grant.
  - Y_VALID rises 2 edges after X_VALID is first sampled high in IDLE.
  - Within a packet, throughput is 1 beat/cycle when Y_READY=1.
  - There is one idle bubble between packets.
- Boundaries:
  - X_VALID low mid-packet: hold the grant and wait indefinitely (no timeout). The other source is blocked.
  - Granted source drops VALID on the grant edge: stay in GRANT_x and wait.
  - Y_READY held low: READY to sources stays 0 and the output is frozen. No beat is lost or duplicated.
  - A single-beat packet (LAST on the first beat) returns to IDLE on the edge after acceptance.
  - Reset asserted mid-packet: everything returns to reset values immediately, regardless of CLK.

Test Plan:
- Reset, then A_VALID=1 with a 3-beat packet (A_DATA=0x11,0x22,0x33, LAST on 0x33), Y_READY=1 -> SEL=0, Y_DATA sequence 0x11,0x22,0x33 on consecutive cycles, Y_LAST only on 0x33, BUSY drops after the last beat.
- A and B both valid from reset (2-beat packets, A=0xA0,0xA1, B=0xB0,0xB1) -> A served first, then one IDLE cycle, then B. Output order 0xA0,0xA1,0xB0,0xB1. SEL 0 then 1.
- Both sources continuously valid for 4 packets -> grant order A,B,A,B. No packet interleaving; every Y_LAST aligns with a source LAST.
- Y_READY=0 for 5 cycles mid-packet (Y_DATA=0x22 pending) -> Y_DATA stays 0x22, A_READY=0 throughout. When released, 0x22 is delivered exactly once and followed by 0x33.
- LOCK_ON_LAST=0, both sources valid, LAST tied 0 -> grant alternates per beat with a bubble between: A,B,A,B.
- RST_N pulsed low between clock edges mid-packet -> Y_VALID=0, SEL=0, BUSY=0 immediately. After release, a new B packet is forwarded correctly.
